matmul_seq_ctrl: RTL and testbench

Sequencer for the 8-bit matrix-multiply accelerator. On start, it walks square matrices A and B held in word-packed SRAMs (4 bytes/word, row-major, 256 words each). It issues reads, accumulates 4 byte-products per cycle, and writes packed 8-bit results into C. It replaces the free-running start/done datapath with a counted, handshaked schedule that software can poll.

---
 rtl/matmul_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the 8-bit matrix-multiply accelerator: walks packed A and B^T, accumulates
// dot products and writes packed C words. Define MATMUL_SAT_EN to saturate element results.
module matmul_seq_ctrl #(
    parameter int MAX_DIM = 32,
    parameter int ADDR_W  = 8,
    parameter int ACC_W   = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [5:0]        dim_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              a_req_o,
    output logic [ADDR_W-1:0] a_addr_o,
    input  logic [31:0]       a_rdata_i,
    output logic              b_req_o,
    output logic [ADDR_W-1:0] b_addr_o,
    input  logic [31:0]       b_rdata_i,
    output logic              c_we_o,
    output logic [ADDR_W-1:0] c_addr_o,
    output logic [31:0]       c_wdata_o
);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, FIN, ERR} state_t;

`ifdef MATMUL_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [5:0]        dim_q, kw_q, i_q, j_q, w_q;
    logic              rd_valid_q;
    logic [ACC_W-1:0]  acc_q, acc_d, prod_sum;
    logic [15:0]       prod [4];
    logic [7:0]        elem;
    logic [31:0]       stage_q;
    logic [ADDR_W-1:0] a_base, b_base;
    logic              dim_legal, last_w, last_i, last_j, word_full;

    assign dim_legal = (dim_i >= 6'd4) && (dim_i[1:0] == 2'b00) && (int'(dim_i) <= MAX_DIM);
    assign last_w    = (w_q == kw_q - 6'd1);
    assign last_i    = (i_q == dim_q - 6'd1);
    assign last_j    = (j_q == dim_q - 6'd1);
    assign word_full = (j_q[1:0] == 2'b11);

    // C shares A's row base because both use the same KW-words-per-row stride.
    assign a_base    = ADDR_W'(i_q) * ADDR_W'(kw_q);
    assign b_base    = ADDR_W'(j_q) * ADDR_W'(kw_q);
    assign a_addr_o  = a_base + ADDR_W'(w_q);
    assign b_addr_o  = b_base + ADDR_W'(w_q);
    assign c_addr_o  = a_base + ADDR_W'(j_q[5:2]);
    assign c_wdata_o = stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d = state_q;
        busy_o  = (state_q != IDLE);
        done_o  = 1'b0;
        err_o   = 1'b0;
        a_req_o = 1'b0;
        b_req_o = 1'b0;
        c_we_o  = 1'b0;
        case (state_q)
            IDLE:  if (start_i) state_d = dim_legal ? RUN : ERR;
            RUN: begin
                a_req_o = 1'b1;
                b_req_o = 1'b1;
                if (last_w) state_d = DRAIN;
            end
            DRAIN: state_d = word_full ? WRITE : RUN;
            WRITE: begin
                c_we_o  = 1'b1;
                state_d = (last_i && last_j) ? FIN : RUN;
            end
            FIN: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                done_o  = 1'b1;
                err_o   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data arrives one cycle after the strobe, so the last word is folded in during DRAIN.
    always_comb begin
        prod_sum = '0;
        for (int n = 0; n < 4; n++) begin
            prod[n]  = a_rdata_i[8*n +: 8] * b_rdata_i[8*n +: 8];
            prod_sum = prod_sum + ACC_W'(prod[n]);
        end
        acc_d = rd_valid_q ? acc_q + prod_sum : acc_q;
        elem  = (SAT_EN && (acc_d > ACC_W'(255))) ? 8'hFF : acc_d[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dim_q      <= '0;
            kw_q       <= '0;
            i_q        <= '0;
            j_q        <= '0;
            w_q        <= '0;
            rd_valid_q <= 1'b0;
            acc_q      <= '0;
            stage_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rd_valid_q <= a_req_o;
            case (state_q)
                IDLE: if (start_i) begin
                    dim_q <= dim_i;
                    kw_q  <= {2'b00, dim_i[5:2]};
                    i_q   <= '0;
                    j_q   <= '0;
                    w_q   <= '0;
                    acc_q <= '0;
                end
                RUN: begin
                    if (!last_w) w_q <= w_q + 6'd1;
                    acc_q <= acc_d;
                end
                DRAIN: begin
                    w_q                      <= '0;
                    acc_q                    <= '0;
                    stage_q[8*j_q[1:0] +: 8] <= elem;
                    if (!word_full) j_q <= j_q + 6'd1;
                end
                WRITE: begin
                    if (last_j) begin
                        j_q <= '0;
                        i_q <= i_q + 6'd1;
                    end else begin
                        j_q <= j_q + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl: word-packed A/B/C memory models, latency,
// strobe counts, illegal DIM, mid-run start, mid-run reset and back-to-back runs.
module tb_matmul_seq_ctrl;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic [5:0]        dim_i = '0;
    logic              busy_o, done_o, err_o;
    logic              a_req_o, b_req_o, c_we_o;
    logic [ADDR_W-1:0] a_addr_o, b_addr_o, c_addr_o;
    logic [31:0]       a_rdata_i, b_rdata_i, c_wdata_o;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] mem_c [256];

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int a_cnt = 0;
    int b_cnt = 0;

    matmul_seq_ctrl #(.MAX_DIM(32), .ADDR_W(ADDR_W), .ACC_W(21)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .dim_i     (dim_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .a_req_o   (a_req_o),
        .a_addr_o  (a_addr_o),
        .a_rdata_i (a_rdata_i),
        .b_req_o   (b_req_o),
        .b_addr_o  (b_addr_o),
        .b_rdata_i (b_rdata_i),
        .c_we_o    (c_we_o),
        .c_addr_o  (c_addr_o),
        .c_wdata_o (c_wdata_o)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM models: read data valid one cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        a_rdata_i <= a_req_o ? mem_a[a_addr_o] : 32'hA5A5_A5A5;
        b_rdata_i <= b_req_o ? mem_b[b_addr_o] : 32'h5A5A_5A5A;
        if (c_we_o) begin
            mem_c[c_addr_o] <= c_wdata_o;
            wr_cnt          <= wr_cnt + 1;
        end
        if (a_req_o) a_cnt <= a_cnt + 1;
        if (b_req_o) b_cnt <= b_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // mode 0: constant bytes va/vb; mode 1: A = identity, B^T row r byte k = 8*r+k.
    task automatic fill(input int dim, input int mode, input logic [7:0] va, input logic [7:0] vb);
        int kw;
        kw = dim / 4;
        for (int r = 0; r < dim; r++) begin
            for (int k = 0; k < dim; k++) begin
                logic [7:0] ab, bb;
                if (mode == 0) begin
                    ab = va;
                    bb = vb;
                end else begin
                    ab = (r == k) ? 8'd1 : 8'd0;
                    bb = 8'(8 * r + k);
                end
                mem_a[r*kw + k/4][8*(k%4) +: 8] = ab;
                mem_b[r*kw + k/4][8*(k%4) +: 8] = bb;
            end
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge where done_o is seen (or on timeout).
    task automatic run_op(input string tag, input logic [5:0] dim, input int exp_lat,
                          input bit exp_err, input int poke_at, input bit hold_start);
        int n;
        dim_i   = dim;
        start_i = 1'b1;
        @(negedge clk);
        n = 1;
        if (!hold_start) start_i = 1'b0;
        while (!done_o && n < 3000) begin
            if (n == poke_at)          start_i = 1'b1;
            else if (n == poke_at + 1) start_i = 1'b0;
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, exp_lat);
        check({tag, " err"}, 32'(err_o), 32'(exp_err));
        check({tag, " busy at done"}, 32'(busy_o), 32'd1);
    endtask

    task automatic check_words(input string tag, input int first, input int count, input logic [31:0] exp);
        for (int a = first; a < first + count; a++) check(tag, mem_c[a], exp);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " busy"},  32'(busy_o),  32'd0);
        check({tag, " done"},  32'(done_o),  32'd0);
        check({tag, " err"},   32'(err_o),   32'd0);
        check({tag, " a_req"}, 32'(a_req_o), 32'd0);
        check({tag, " b_req"}, 32'(b_req_o), 32'd0);
        check({tag, " c_we"},  32'(c_we_o),  32'd0);
        check({tag, " a_addr"}, 32'(a_addr_o), 32'd0);
        check({tag, " b_addr"}, 32'(b_addr_o), 32'd0);
        check({tag, " c_addr"}, 32'(c_addr_o), 32'd0);
        check({tag, " c_wdata"}, c_wdata_o, 32'd0);
    endtask

    initial begin
        int wr0, a0, b0, cyc;
        logic [31:0] exp_w;

        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: DIM=4, A=2, B=4 -> 4*8 = 32 per element.
        fill(4, 0, 8'd2, 8'd4);
        wr0 = wr_cnt; a0 = a_cnt; b0 = b_cnt;
        run_op("t1", 6'd4, 37, 1'b0, -10, 1'b0);
        @(negedge clk);
        check("t1 done pulse", 32'(done_o), 32'd0);
        check("t1 busy idle", 32'(busy_o), 32'd0);
        check("t1 writes", wr_cnt - wr0, 4);
        check("t1 a reads", a_cnt - a0, 16);
        check("t1 b reads", b_cnt - b0, 16);
        check_words("t1 c", 0, 4, 32'h2020_2020);

        // 2: A=B=255 -> 4*65025 = 260100 = 0x3F804, wraps to 0x04.
        fill(4, 0, 8'hFF, 8'hFF);
        @(negedge clk);
        run_op("t2", 6'd4, 37, 1'b0, -10, 1'b0);
        @(negedge clk);
`ifdef MATMUL_SAT_EN
        exp_w = 32'hFFFF_FFFF;
`else
        exp_w = 32'h0404_0404;
`endif
        check_words("t2 c", 0, 4, exp_w);

        // 3: DIM=8 identity times B -> C[i][j] = B[i][j] = B^T[j][i] = 8*j+i.
        fill(8, 1, 8'd0, 8'd0);
        wr0 = wr_cnt; a0 = a_cnt;
        @(negedge clk);
        run_op("t3", 6'd8, 209, 1'b0, -10, 1'b0);
        @(negedge clk);
        check("t3 writes", wr_cnt - wr0, 16);
        check("t3 a reads", a_cnt - a0, 128);
        for (int i = 0; i < 8; i++) begin
            for (int wj = 0; wj < 2; wj++) begin
                for (int n = 0; n < 4; n++) exp_w[8*n +: 8] = 8'(8 * (4*wj + n) + i);
                check("t3 c", mem_c[i*2 + wj], exp_w);
            end
        end

        // 4: illegal DIMs -> done+err one cycle after start, no strobes.
        wr0 = wr_cnt; a0 = a_cnt;
        run_op("t4 dim6", 6'd6, 1, 1'b1, -10, 1'b0);
        @(negedge clk);
        run_op("t4 dim0", 6'd0, 1, 1'b1, -10, 1'b0);
        @(negedge clk);
        run_op("t4 dim36", 6'd36, 1, 1'b1, -10, 1'b0);
        @(negedge clk);
        check("t4 no a_req", a_cnt - a0, 0);
        check("t4 no c_we", wr_cnt - wr0, 0);

        // 5a: start re-pulsed mid-run is ignored.
        fill(4, 0, 8'd2, 8'd4);
        wr0 = wr_cnt;
        run_op("t5 poke", 6'd4, 37, 1'b0, 10, 1'b0);
        @(negedge clk);
        check("t5 poke writes", wr_cnt - wr0, 4);
        check_words("t5 poke c", 0, 4, 32'h2020_2020);

        // 5b: reset after the second write aborts at once.
        fill(4, 0, 8'd3, 8'd5);
        dim_i = 6'd4;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wr0 = wr_cnt;
        cyc = 0;
        while (wr_cnt < wr0 + 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("t5 reach 2nd write", wr_cnt - wr0, 2);
        rst_n = 1'b0;
        #1;
        check_idle_zero("t5 in reset");
        wr0 = wr_cnt; a0 = a_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t5 no reads after rst", a_cnt - a0, 0);
        check("t5 no writes after rst", wr_cnt - wr0, 0);
        check("t5 idle after rst", 32'(busy_o), 32'd0);

        // 5c: a fresh run after reset: 4*15 = 60 = 0x3C.
        wr0 = wr_cnt;
        run_op("t5 rerun", 6'd4, 37, 1'b0, -10, 1'b0);
        @(negedge clk);
        check("t5 rerun writes", wr_cnt - wr0, 4);
        check_words("t5 rerun c", 0, 4, 32'h3C3C_3C3C);

        // 6: start held high -> exactly one IDLE cycle between runs; 4*7 = 28 = 0x1C.
        fill(4, 0, 8'd1, 8'd7);
        wr0 = wr_cnt;
        run_op("t6 run1", 6'd4, 37, 1'b0, -10, 1'b1);
        @(negedge clk);
        check("t6 gap busy", 32'(busy_o), 32'd0);
        run_op("t6 run2", 6'd4, 37, 1'b0, -10, 1'b1);
        start_i = 1'b0;
        @(negedge clk);
        check("t6 final idle", 32'(busy_o), 32'd0);
        @(negedge clk);
        check("t6 stays idle", 32'(busy_o), 32'd0);
        check("t6 writes", wr_cnt - wr0, 8);
        check_words("t6 c", 0, 4, 32'h1C1C_1C1C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
